// File: rtl/inv3f_mem_writer_if.sv
// Handshake and memory-write bundle for inv3f_mem_writer.
//   master : drives start, in_valid, in_data; observes everything else
//   slave  : the writer itself; accepts coefficients and emits memory writes
//   start/in_valid/in_data  : load request and coefficient stream (in_data signed 16b)
//   in_ready                : writer accepts in_data this cycle
//   write_enable/write_address/input_data : memory write port
//   busy/done               : status, done is a one-cycle completion pulse
interface inv3f_mem_writer_if #(
  parameter int unsigned RAM_WIDTH     = 13,
  parameter int unsigned RAM_ADDR_BITS = 11
);
  logic                     start;
  logic                     in_valid;
  logic [15:0]              in_data;
  logic                     in_ready;
  logic                     write_enable;
  logic [RAM_ADDR_BITS-1:0] write_address;
  logic [RAM_WIDTH-1:0]     input_data;
  logic                     busy;
  logic                     done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, write_enable, write_address, input_data, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, write_enable, write_address, input_data, busy, done
  );
endinterface

// File: rtl/inv3f_mem_writer.sv
// Loads P signed coefficients into a memory, reducing each into [0, Q-1].
// Every accepted coefficient is written one cycle later at the next address.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : inv3f_mem_writer_if slave (start/in_valid/in_data in;
//                in_ready, write_enable, write_address, input_data, busy, done out)
// Optional feature: define INV3F_ZERO_PAD_EN to zero-fill addresses P..2^RAM_ADDR_BITS-1
// after the last coefficient.
module inv3f_mem_writer #(
  parameter int unsigned P             = 757,
  parameter int unsigned Q             = 4591,
  parameter int unsigned RAM_WIDTH     = 13,
  parameter int unsigned RAM_ADDR_BITS = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inv3f_mem_writer_if.slave     bus
);

  localparam int unsigned CNT_W     = RAM_ADDR_BITS + 1;
  // Smallest multiple of Q that lifts any 16-bit signed value to non-negative.
  localparam int unsigned BIAS      = ((32768 + Q - 1) / Q) * Q;
  localparam int unsigned ADDR_LAST = (32'(1) << RAM_ADDR_BITS) - 1;

  typedef enum logic [1:0] {IDLE, LOAD, PAD, FLUSH} state_e;

`ifdef INV3F_ZERO_PAD_EN
  localparam state_e AFTER_LOAD = (P <= ADDR_LAST) ? PAD : FLUSH;
`else
  localparam state_e AFTER_LOAD = FLUSH;
`endif

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     in_ready_q, in_ready_d;
  logic                     write_enable_q, write_enable_d;
  logic [RAM_ADDR_BITS-1:0] write_address_q, write_address_d;
  logic [RAM_WIDTH-1:0]     input_data_q, input_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic signed [31:0]       coef_ext;
  logic [31:0]              coef_biased;
  logic [RAM_WIDTH-1:0]     coef_frozen;

  // Coefficient freeze: bias into the non-negative range, then reduce mod Q.
  always_comb begin
    coef_ext    = 32'(signed'(bus.in_data));
    coef_biased = unsigned'(coef_ext) + BIAS;
    coef_frozen = RAM_WIDTH'(coef_biased % Q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    input_data_d    = input_data_q;
    done_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          write_enable_d  = 1'b1;
          write_address_d = RAM_ADDR_BITS'(cnt_q);
          input_data_d    = coef_frozen;
          cnt_d           = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(P - 1)) state_d = AFTER_LOAD;
        end
      end
      PAD: begin
        write_enable_d  = 1'b1;
        write_address_d = RAM_ADDR_BITS'(cnt_q);
        input_data_d    = '0;
        cnt_d           = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ADDR_LAST)) state_d = FLUSH;
      end
      FLUSH: begin
        // The final write is on the bus this cycle; done follows it.
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they track state_q exactly.
    in_ready_d = (state_d == LOAD) && (cnt_d < CNT_W'(P));
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      in_ready_q      <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      input_data_q    <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      in_ready_q      <= in_ready_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      input_data_q    <= input_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.input_data    = input_data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule
